// File: rtl/rename_scoreboard_if.sv
// -----------------------------------------------------------------------------
// rename_scoreboard_if
// Bundles the issue, FU read/write and register-file channels of the rename
// scoreboard.
//   slave  : the scoreboard side (takes issue/FU requests, drives the RF side)
//   master : the environment side (decode/issue, FUs and register file)
// Signal groups:
//   fu_available, issue_*            issue handshake and rename results
//   fu2sb_read_* / sb2rf_read_*      per-FU operand read request, gated
//   fu2sb_write_* / sb2rf_write_*    per-FU write-back, passthrough
//   free_reg_cnt                     number of allocatable physical registers
// -----------------------------------------------------------------------------
interface rename_scoreboard_if #(
    parameter int NUM_AREG = 8,
    parameter int NUM_PREG = 16,
    parameter int NUM_FU   = 4,
    parameter int REG_BIT  = 16
);
    localparam int AREG_ID_BIT = $clog2(NUM_AREG);
    localparam int PREG_ID_BIT = $clog2(NUM_PREG);
    localparam int FU_ID_BIT   = $clog2(NUM_FU);

    logic [NUM_FU-1:0]             fu_available;
    logic                          issue_vld;
    logic                          issue_rdy;
    logic [FU_ID_BIT-1:0]          issue_fu;
    logic [AREG_ID_BIT-1:0]        issue_dst_reg;
    logic [AREG_ID_BIT-1:0]        issue_src_reg0;
    logic [AREG_ID_BIT-1:0]        issue_src_reg1;
    logic [PREG_ID_BIT-1:0]        issue_dst_reg_rename;
    logic [PREG_ID_BIT-1:0]        issue_src_reg0_rename;
    logic [PREG_ID_BIT-1:0]        issue_src_reg1_rename;

    logic [NUM_FU-1:0]             fu2sb_read_reg_id_vld;
    logic [NUM_FU-1:0]             fu2sb_read_reg_id_rdy;
    logic [NUM_FU*PREG_ID_BIT-1:0] fu2sb_read_reg0_id;
    logic [NUM_FU*PREG_ID_BIT-1:0] fu2sb_read_reg1_id;
    logic [NUM_FU-1:0]             sb2rf_read_reg_id_vld;
    logic [NUM_FU-1:0]             sb2rf_read_reg_id_rdy;
    logic [NUM_FU*PREG_ID_BIT-1:0] sb2rf_read_reg0_id;
    logic [NUM_FU*PREG_ID_BIT-1:0] sb2rf_read_reg1_id;

    logic [NUM_FU-1:0]             fu2sb_write_reg_id_vld;
    logic [NUM_FU-1:0]             fu2sb_write_reg_id_rdy;
    logic [NUM_FU*PREG_ID_BIT-1:0] fu2sb_write_reg_id;
    logic [NUM_FU*REG_BIT-1:0]     fu2sb_write_data;
    logic [NUM_FU-1:0]             sb2rf_write_reg_id_vld;
    logic [NUM_FU-1:0]             sb2rf_write_reg_id_rdy;
    logic [NUM_FU*PREG_ID_BIT-1:0] sb2rf_write_reg_id;
    logic [NUM_FU*REG_BIT-1:0]     sb2rf_write_data;

    logic [PREG_ID_BIT:0]          free_reg_cnt;

    modport slave (
        input  fu_available, issue_vld, issue_fu, issue_dst_reg, issue_src_reg0, issue_src_reg1,
        output issue_rdy, issue_dst_reg_rename, issue_src_reg0_rename, issue_src_reg1_rename,
        input  fu2sb_read_reg_id_vld, fu2sb_read_reg0_id, fu2sb_read_reg1_id,
        output fu2sb_read_reg_id_rdy,
        output sb2rf_read_reg_id_vld, sb2rf_read_reg0_id, sb2rf_read_reg1_id,
        input  sb2rf_read_reg_id_rdy,
        input  fu2sb_write_reg_id_vld, fu2sb_write_reg_id, fu2sb_write_data,
        output fu2sb_write_reg_id_rdy,
        output sb2rf_write_reg_id_vld, sb2rf_write_reg_id, sb2rf_write_data,
        input  sb2rf_write_reg_id_rdy,
        output free_reg_cnt
    );

    modport master (
        output fu_available, issue_vld, issue_fu, issue_dst_reg, issue_src_reg0, issue_src_reg1,
        input  issue_rdy, issue_dst_reg_rename, issue_src_reg0_rename, issue_src_reg1_rename,
        output fu2sb_read_reg_id_vld, fu2sb_read_reg0_id, fu2sb_read_reg1_id,
        input  fu2sb_read_reg_id_rdy,
        input  sb2rf_read_reg_id_vld, sb2rf_read_reg0_id, sb2rf_read_reg1_id,
        output sb2rf_read_reg_id_rdy,
        output fu2sb_write_reg_id_vld, fu2sb_write_reg_id, fu2sb_write_data,
        input  fu2sb_write_reg_id_rdy,
        input  sb2rf_write_reg_id_vld, sb2rf_write_reg_id, sb2rf_write_data,
        output sb2rf_write_reg_id_rdy,
        input  free_reg_cnt
    );
endinterface

// File: rtl/rename_scoreboard.sv
// -----------------------------------------------------------------------------
// rename_scoreboard
// Single-issue register renaming scoreboard. Maps NUM_AREG architectural
// registers onto NUM_PREG physical registers, tracks outstanding writes and
// outstanding readers per physical register, holds FU operand reads until the
// producer has written back, and recycles a physical register once it is
// unmapped, written and unread.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   sb     rename_scoreboard_if.slave: issue handshake + renames, per-FU read
//          request gated towards the RF, per-FU write-back passthrough,
//          free_reg_cnt.
// All outputs are combinational from registered state and current inputs.
// -----------------------------------------------------------------------------
module rename_scoreboard #(
    parameter int NUM_AREG    = 8,
    parameter int NUM_PREG    = 16,
    parameter int NUM_FU      = 4,
    parameter int REG_BIT     = 16,
    parameter int CNT_BIT     = 3,
    parameter int AREG_ID_BIT = $clog2(NUM_AREG),
    parameter int PREG_ID_BIT = $clog2(NUM_PREG),
    parameter int FU_ID_BIT   = $clog2(NUM_FU)
) (
    input  logic              clk,
    input  logic              rst_n,
    rename_scoreboard_if.slave sb
);
    localparam int FREE_BIT = PREG_ID_BIT + 1;
    localparam int SAT_BIT  = CNT_BIT + 2;

    localparam logic [CNT_BIT-1:0]  CNT_ONE  = {{(CNT_BIT-1){1'b0}}, 1'b1};
    localparam logic [CNT_BIT-1:0]  CNT_ZERO = {CNT_BIT{1'b0}};
    localparam logic [SAT_BIT-1:0]  SAT_MAX  = {2'b00, {CNT_BIT{1'b1}}};
    localparam logic [SAT_BIT-1:0]  INC_ONE  = {{(SAT_BIT-1){1'b0}}, 1'b1};
    localparam logic [SAT_BIT-1:0]  INC_TWO  = {{(SAT_BIT-2){1'b0}}, 2'b10};
    localparam logic [NUM_PREG-1:0] MAPPED_RST =
        {{(NUM_PREG-NUM_AREG){1'b0}}, {NUM_AREG{1'b1}}};

    // Architectural state
    logic [PREG_ID_BIT-1:0] map_r      [NUM_AREG];
    logic [NUM_PREG-1:0]    mapped_r;
    logic [NUM_PREG-1:0]    wr_pend_r;
    logic [CNT_BIT-1:0]     rd_cnt_r   [NUM_PREG];

    logic [PREG_ID_BIT-1:0] map_nxt_s    [NUM_AREG];
    logic [NUM_PREG-1:0]    mapped_nxt_s;
    logic [NUM_PREG-1:0]    wr_pend_nxt_s;
    logic [CNT_BIT-1:0]     rd_cnt_nxt_s [NUM_PREG];

    // Allocation
    logic [NUM_PREG-1:0]    free_s;
    logic [PREG_ID_BIT-1:0] alloc_s;
    logic [FREE_BIT-1:0]    free_cnt_s;

    // Issue side
    logic [FU_ID_BIT-1:0]   issue_fu_s;
    logic [AREG_ID_BIT-1:0] dst_s;
    logic [AREG_ID_BIT-1:0] src0_s;
    logic [AREG_ID_BIT-1:0] src1_s;
    logic                   dst_vld_s;
    logic                   src0_vld_s;
    logic                   src1_vld_s;
    logic [PREG_ID_BIT-1:0] src0_phys_s;
    logic [PREG_ID_BIT-1:0] src1_phys_s;
    logic [PREG_ID_BIT-1:0] dst_old_s;
    logic [SAT_BIT-1:0]     src_inc_s;
    logic                   sat0_s;
    logic                   sat1_s;
    logic                   issue_rdy_s;
    logic                   issue_hs_s;
    logic                   dst_upd_s;

    // FU channels
    logic [PREG_ID_BIT-1:0] rd_reg0_s [NUM_FU];
    logic [PREG_ID_BIT-1:0] rd_reg1_s [NUM_FU];
    logic [PREG_ID_BIT-1:0] wr_reg_s  [NUM_FU];
    logic [NUM_FU-1:0]      rd_ok_s;
    logic [NUM_FU-1:0]      rd_hs_s;
    logic [NUM_FU-1:0]      wr_hs_s;
    logic [NUM_FU*REG_BIT-1:0] wr_data_s;

    // Free vector: unmapped, no write pending, no outstanding readers; phys 0 never free
    always_comb begin
        free_s = '0;
        for (int p = 1; p < NUM_PREG; p++) begin
            free_s[p] = !mapped_r[p] && !wr_pend_r[p] && (rd_cnt_r[p] == CNT_ZERO);
        end
    end

    // Lowest-index free register and population count of the free vector
    always_comb begin
        alloc_s    = '0;
        free_cnt_s = '0;
        for (int p = NUM_PREG - 1; p >= 0; p--) begin
            alloc_s    = free_s[p] ? PREG_ID_BIT'(p) : alloc_s;
            free_cnt_s = free_cnt_s + FREE_BIT'(free_s[p]);
        end
    end

    assign issue_fu_s = sb.issue_fu;
    assign dst_s      = sb.issue_dst_reg;
    assign src0_s     = sb.issue_src_reg0;
    assign src1_s     = sb.issue_src_reg1;
    assign dst_vld_s  = (dst_s  != '0);
    assign src0_vld_s = (src0_s != '0);
    assign src1_vld_s = (src1_s != '0);

    // Sources rename through the pre-issue map, so dst==src reads the old phys
    assign src0_phys_s = src0_vld_s ? map_r[src0_s] : '0;
    assign src1_phys_s = src1_vld_s ? map_r[src1_s] : '0;
    assign dst_old_s   = map_r[dst_s];

    // Reading the same register twice adds two readers to one counter
    assign src_inc_s = (src0_s == src1_s) ? INC_TWO : INC_ONE;
    assign sat0_s    = src0_vld_s && (({2'b00, rd_cnt_r[src0_phys_s]} + src_inc_s) > SAT_MAX);
    assign sat1_s    = src1_vld_s && (({2'b00, rd_cnt_r[src1_phys_s]} + src_inc_s) > SAT_MAX);

    assign issue_rdy_s = sb.fu_available[issue_fu_s]
                         && (!dst_vld_s || (free_cnt_s != '0))
                         && !sat0_s && !sat1_s;
    assign issue_hs_s  = sb.issue_vld && issue_rdy_s;
    assign dst_upd_s   = issue_hs_s && dst_vld_s;

    assign sb.issue_rdy             = issue_rdy_s;
    assign sb.issue_src_reg0_rename = src0_phys_s;
    assign sb.issue_src_reg1_rename = src1_phys_s;
    assign sb.issue_dst_reg_rename  = dst_vld_s ? alloc_s : '0;
    assign sb.free_reg_cnt          = free_cnt_s;

    // Unpack per-FU register ids and decide whether each operand read may proceed
    always_comb begin
        rd_reg0_s = '{default: '0};
        rd_reg1_s = '{default: '0};
        wr_reg_s  = '{default: '0};
        rd_ok_s   = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            rd_reg0_s[f] = sb.fu2sb_read_reg0_id[f*PREG_ID_BIT +: PREG_ID_BIT];
            rd_reg1_s[f] = sb.fu2sb_read_reg1_id[f*PREG_ID_BIT +: PREG_ID_BIT];
            wr_reg_s[f]  = sb.fu2sb_write_reg_id[f*PREG_ID_BIT +: PREG_ID_BIT];
            rd_ok_s[f]   = !wr_pend_r[rd_reg0_s[f]] && !wr_pend_r[rd_reg1_s[f]];
        end
    end

    assign sb.sb2rf_read_reg_id_vld = sb.fu2sb_read_reg_id_vld & rd_ok_s;
    assign sb.fu2sb_read_reg_id_rdy = sb.sb2rf_read_reg_id_rdy & rd_ok_s;
    assign sb.sb2rf_read_reg0_id    = sb.fu2sb_read_reg0_id;
    assign sb.sb2rf_read_reg1_id    = sb.fu2sb_read_reg1_id;
    assign rd_hs_s = sb.fu2sb_read_reg_id_vld & sb.sb2rf_read_reg_id_rdy & rd_ok_s;

    assign wr_data_s                 = sb.fu2sb_write_data;
    assign sb.sb2rf_write_reg_id_vld = sb.fu2sb_write_reg_id_vld;
    assign sb.fu2sb_write_reg_id_rdy = sb.sb2rf_write_reg_id_rdy;
    assign sb.sb2rf_write_reg_id     = sb.fu2sb_write_reg_id;
    assign sb.sb2rf_write_data       = wr_data_s;
    assign wr_hs_s = sb.fu2sb_write_reg_id_vld & sb.sb2rf_write_reg_id_rdy;

    // Next state: write-back clears, reader decrements, then issue effects
    always_comb begin
        map_nxt_s     = map_r;
        mapped_nxt_s  = mapped_r;
        wr_pend_nxt_s = wr_pend_r;
        rd_cnt_nxt_s  = rd_cnt_r;

        for (int f = 0; f < NUM_FU; f++) begin
            wr_pend_nxt_s[wr_reg_s[f]] = wr_hs_s[f] ? 1'b0 : wr_pend_nxt_s[wr_reg_s[f]];
            // Equal nonzero ids on both ports take two decrements from one counter
            rd_cnt_nxt_s[rd_reg0_s[f]] = rd_cnt_nxt_s[rd_reg0_s[f]]
                - ((rd_hs_s[f] && (rd_reg0_s[f] != '0)) ? CNT_ONE : CNT_ZERO);
            rd_cnt_nxt_s[rd_reg1_s[f]] = rd_cnt_nxt_s[rd_reg1_s[f]]
                - ((rd_hs_s[f] && (rd_reg1_s[f] != '0)) ? CNT_ONE : CNT_ZERO);
        end

        rd_cnt_nxt_s[src0_phys_s] = rd_cnt_nxt_s[src0_phys_s]
            + ((issue_hs_s && src0_vld_s) ? CNT_ONE : CNT_ZERO);
        rd_cnt_nxt_s[src1_phys_s] = rd_cnt_nxt_s[src1_phys_s]
            + ((issue_hs_s && src1_vld_s) ? CNT_ONE : CNT_ZERO);

        // alloc is never pending, so its set cannot collide with a same-cycle clear
        map_nxt_s[dst_s]       = dst_upd_s ? alloc_s : map_r[dst_s];
        mapped_nxt_s[dst_old_s] = dst_upd_s ? 1'b0 : mapped_r[dst_old_s];
        mapped_nxt_s[alloc_s]  = dst_upd_s ? 1'b1 : mapped_nxt_s[alloc_s];
        wr_pend_nxt_s[alloc_s] = dst_upd_s ? 1'b1 : wr_pend_nxt_s[alloc_s];
    end

    // State registers with synchronous active-low reset to the identity mapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_AREG; i++) begin
                map_r[i] <= PREG_ID_BIT'(i);
            end
            for (int p = 0; p < NUM_PREG; p++) begin
                rd_cnt_r[p] <= CNT_ZERO;
            end
            mapped_r  <= MAPPED_RST;
            wr_pend_r <= '0;
        end else begin
            map_r     <= map_nxt_s;
            mapped_r  <= mapped_nxt_s;
            wr_pend_r <= wr_pend_nxt_s;
            rd_cnt_r  <= rd_cnt_nxt_s;
        end
    end
endmodule

// File: tb/tb_rename_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_rename_scoreboard
// Randomised bench for rename_scoreboard. A behavioural model (arch->phys map,
// pending-write flags, integer reader counts, per-FU op queues) predicts every
// output each cycle; FU traffic is generated from the ops the model issued so
// the read/write protocol is always legal.
// -----------------------------------------------------------------------------
module tb_rename_scoreboard;
    localparam int NUM_AREG = 8;
    localparam int NUM_PREG = 16;
    localparam int NUM_FU   = 4;
    localparam int REG_BIT  = 16;
    localparam int CNT_BIT  = 3;
    localparam int PB       = 4;
    localparam int CNT_MAX  = (1 << CNT_BIT) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rename_scoreboard_if #(.NUM_AREG(NUM_AREG), .NUM_PREG(NUM_PREG), .NUM_FU(NUM_FU),
                           .REG_BIT(REG_BIT)) sb_if ();

    rename_scoreboard #(.NUM_AREG(NUM_AREG), .NUM_PREG(NUM_PREG), .NUM_FU(NUM_FU),
                        .REG_BIT(REG_BIT), .CNT_BIT(CNT_BIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int fu; int s0; int s1; int d; } op_t;
    int  map_m     [NUM_AREG];
    bit  pend_m    [NUM_PREG];
    int  readers_m [NUM_PREG];
    op_t rq[$];
    op_t wq[$];

    function automatic void model_reset();
        for (int a = 0; a < NUM_AREG; a++) map_m[a] = a;
        for (int p = 0; p < NUM_PREG; p++) begin
            pend_m[p]    = 1'b0;
            readers_m[p] = 0;
        end
        rq.delete();
        wq.delete();
    endfunction

    function automatic bit is_free(input int p);
        if (p == 0 || pend_m[p] || readers_m[p] != 0) return 1'b0;
        for (int a = 0; a < NUM_AREG; a++) if (map_m[a] == p) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int find_rq(input int f);
        foreach (rq[i]) if (rq[i].fu == f) return i;
        return -1;
    endfunction

    function automatic int find_wq(input int f);
        foreach (wq[i]) if (wq[i].fu == f) return i;
        return -1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive_idle();
        sb_if.fu_available           = 4'hF;
        sb_if.issue_vld              = 1'b0;
        sb_if.issue_fu               = 2'd0;
        sb_if.issue_dst_reg          = 3'd0;
        sb_if.issue_src_reg0         = 3'd0;
        sb_if.issue_src_reg1         = 3'd0;
        sb_if.fu2sb_read_reg_id_vld  = 4'd0;
        sb_if.fu2sb_read_reg0_id     = 16'd0;
        sb_if.fu2sb_read_reg1_id     = 16'd0;
        sb_if.sb2rf_read_reg_id_rdy  = 4'd0;
        sb_if.fu2sb_write_reg_id_vld = 4'd0;
        sb_if.fu2sb_write_reg_id     = 16'd0;
        sb_if.fu2sb_write_data       = 64'd0;
        sb_if.sb2rf_write_reg_id_rdy = 4'd0;
    endtask

    task automatic drive_random(input int p_issue, input int p_rrdy, input int p_wrdy, input bit bias);
        int idx;
        sb_if.fu_available   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        sb_if.issue_vld      = ($urandom_range(0, 99) < p_issue);
        sb_if.issue_fu       = 2'($urandom);
        sb_if.issue_dst_reg  = 3'($urandom);
        sb_if.issue_src_reg0 = (bias && $urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom);
        sb_if.issue_src_reg1 = (bias && $urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom);
        for (int f = 0; f < NUM_FU; f++) begin
            idx = find_rq(f);
            sb_if.fu2sb_read_reg_id_vld[f] = (idx >= 0) && ($urandom_range(0, 3) != 0);
            sb_if.fu2sb_read_reg0_id[f*PB +: PB] = (idx >= 0) ? 4'(rq[idx].s0) : 4'($urandom);
            sb_if.fu2sb_read_reg1_id[f*PB +: PB] = (idx >= 0) ? 4'(rq[idx].s1) : 4'($urandom);
            sb_if.sb2rf_read_reg_id_rdy[f] = ($urandom_range(0, 99) < p_rrdy);
            idx = find_wq(f);
            sb_if.fu2sb_write_reg_id_vld[f] = (idx >= 0) && ($urandom_range(0, 3) != 0);
            sb_if.fu2sb_write_reg_id[f*PB +: PB] = (idx >= 0) ? 4'(wq[idx].d) : 4'($urandom);
            sb_if.fu2sb_write_data[f*REG_BIT +: REG_BIT] = 16'($urandom);
            sb_if.sb2rf_write_reg_id_rdy[f] = ($urandom_range(0, 99) < p_wrdy);
        end
    endtask

    // One cycle: predict and compare outputs, then advance the model at the edge
    task automatic step();
        int s0, s1, d, fu, p0, p1, alloc, nfree, inc, r0, r1, idx;
        bit sat, exp_rdy, ihs;
        logic [NUM_FU-1:0] ok, rhs, whs;
        op_t op;
        #1;
        s0 = int'(sb_if.issue_src_reg0);
        s1 = int'(sb_if.issue_src_reg1);
        d  = int'(sb_if.issue_dst_reg);
        fu = int'(sb_if.issue_fu);
        p0 = (s0 == 0) ? 0 : map_m[s0];
        p1 = (s1 == 0) ? 0 : map_m[s1];
        nfree = 0;
        alloc = 0;
        for (int p = NUM_PREG - 1; p >= 1; p--) begin
            if (is_free(p)) begin
                nfree++;
                alloc = p;
            end
        end
        inc = (s0 == s1) ? 2 : 1;
        sat = (s0 != 0 && readers_m[p0] + inc > CNT_MAX) || (s1 != 0 && readers_m[p1] + inc > CNT_MAX);
        exp_rdy = sb_if.fu_available[fu] && (d == 0 || nfree > 0) && !sat;

        check_val("issue_rdy", 64'(sb_if.issue_rdy), 64'(exp_rdy));
        check_val("src0_rename", 64'(sb_if.issue_src_reg0_rename), 64'(p0));
        check_val("src1_rename", 64'(sb_if.issue_src_reg1_rename), 64'(p1));
        if (d == 0) check_val("dst_rename_none", 64'(sb_if.issue_dst_reg_rename), 64'd0);
        else if (nfree > 0) check_val("dst_rename", 64'(sb_if.issue_dst_reg_rename), 64'(alloc));
        check_val("free_reg_cnt", 64'(sb_if.free_reg_cnt), 64'(nfree));

        for (int f = 0; f < NUM_FU; f++) begin
            r0 = int'(sb_if.fu2sb_read_reg0_id[f*PB +: PB]);
            r1 = int'(sb_if.fu2sb_read_reg1_id[f*PB +: PB]);
            ok[f] = !pend_m[r0] && !pend_m[r1];
        end
        check_val("rd_vld", 64'(sb_if.sb2rf_read_reg_id_vld), 64'(sb_if.fu2sb_read_reg_id_vld & ok));
        check_val("rd_rdy", 64'(sb_if.fu2sb_read_reg_id_rdy), 64'(sb_if.sb2rf_read_reg_id_rdy & ok));
        check_val("rd_id0", 64'(sb_if.sb2rf_read_reg0_id), 64'(sb_if.fu2sb_read_reg0_id));
        check_val("rd_id1", 64'(sb_if.sb2rf_read_reg1_id), 64'(sb_if.fu2sb_read_reg1_id));
        check_val("wr_vld", 64'(sb_if.sb2rf_write_reg_id_vld), 64'(sb_if.fu2sb_write_reg_id_vld));
        check_val("wr_rdy", 64'(sb_if.fu2sb_write_reg_id_rdy), 64'(sb_if.sb2rf_write_reg_id_rdy));
        check_val("wr_id", 64'(sb_if.sb2rf_write_reg_id), 64'(sb_if.fu2sb_write_reg_id));
        check_val("wr_data", sb_if.sb2rf_write_data, sb_if.fu2sb_write_data);

        rhs = sb_if.fu2sb_read_reg_id_vld & sb_if.sb2rf_read_reg_id_rdy & ok;
        whs = sb_if.fu2sb_write_reg_id_vld & sb_if.sb2rf_write_reg_id_rdy;
        ihs = sb_if.issue_vld && exp_rdy;

        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (rhs[f]) begin
                    idx = find_rq(f);
                    op  = rq[idx];
                    if (op.s0 != 0) readers_m[op.s0]--;
                    if (op.s1 != 0) readers_m[op.s1]--;
                    if (op.d != 0) wq.push_back(op);
                    rq.delete(idx);
                end
            end
            for (int f = 0; f < NUM_FU; f++) begin
                if (whs[f]) begin
                    idx = find_wq(f);
                    pend_m[wq[idx].d] = 1'b0;
                    wq.delete(idx);
                end
            end
            if (ihs) begin
                if (s0 != 0) readers_m[p0]++;
                if (s1 != 0) readers_m[p1]++;
                if (d != 0) begin
                    pend_m[alloc] = 1'b1;
                    map_m[d]      = alloc;
                end
                op = '{fu: fu, s0: p0, s1: p1, d: (d != 0) ? alloc : 0};
                rq.push_back(op);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset values with idle inputs, then issue r3 = r1 op r2
        sb_if.issue_vld      = 1'b1;
        sb_if.issue_dst_reg  = 3'd3;
        sb_if.issue_src_reg0 = 3'd1;
        sb_if.issue_src_reg1 = 3'd2;
        #1;
        check_val("t1_free_rst", 64'(sb_if.free_reg_cnt), 64'd8);
        check_val("t1_rdy", 64'(sb_if.issue_rdy), 64'd1);
        check_val("t1_dst", 64'(sb_if.issue_dst_reg_rename), 64'd8);
        check_val("t1_src0", 64'(sb_if.issue_src_reg0_rename), 64'd1);
        check_val("t1_src1", 64'(sb_if.issue_src_reg1_rename), 64'd2);
        step();
        drive_idle();
        sb_if.issue_src_reg0 = 3'd3;
        #1;
        check_val("t1_free_after", 64'(sb_if.free_reg_cnt), 64'd8);
        check_val("t1_map3", 64'(sb_if.issue_src_reg0_rename), 64'd8);
        step();

        // Balanced random traffic
        for (int i = 0; i < 1000; i++) begin
            drive_random(60, 70, 70, 1'b0);
            step();
        end

        // Congested: reads and write-backs rarely accepted -> saturation and exhaustion
        for (int i = 0; i < 600; i++) begin
            drive_random(90, 10, 5, 1'b1);
            step();
        end

        // Mid-stream reset for one cycle
        drive_random(60, 50, 50, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive_idle();
        sb_if.issue_dst_reg  = 3'd5;
        sb_if.issue_src_reg0 = 3'd6;
        sb_if.issue_src_reg1 = 3'd7;
        #1;
        check_val("rst_free", 64'(sb_if.free_reg_cnt), 64'd8);
        check_val("rst_dst", 64'(sb_if.issue_dst_reg_rename), 64'd8);
        check_val("rst_src0", 64'(sb_if.issue_src_reg0_rename), 64'd6);
        check_val("rst_src1", 64'(sb_if.issue_src_reg1_rename), 64'd7);
        step();

        // Reader-counter saturation: seven reads of r1 outstanding blocks the eighth
        for (int i = 0; i < 7; i++) begin
            drive_idle();
            sb_if.issue_vld      = 1'b1;
            sb_if.issue_src_reg0 = 3'd1;
            step();
        end
        drive_idle();
        sb_if.issue_vld      = 1'b1;
        sb_if.issue_src_reg0 = 3'd1;
        #1;
        check_val("sat_block", 64'(sb_if.issue_rdy), 64'd0);
        step();
        drive_idle();
        sb_if.fu2sb_read_reg_id_vld = 4'b0001;
        sb_if.fu2sb_read_reg0_id    = 16'h0001;
        sb_if.sb2rf_read_reg_id_rdy = 4'b0001;
        step();
        drive_idle();
        sb_if.issue_vld      = 1'b1;
        sb_if.issue_src_reg0 = 3'd1;
        #1;
        check_val("sat_release", 64'(sb_if.issue_rdy), 64'd1);
        step();

        // Mixed traffic after saturation, then balanced drain
        for (int i = 0; i < 400; i++) begin
            drive_random(85, 20, 15, 1'b0);
            step();
        end
        for (int i = 0; i < 800; i++) begin
            drive_random(40, 80, 80, 1'b0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
